// File: rtl/sa_sched_pkg.sv
// Shared constants for the conv-layer scheduler: FSM encodings, per-layer
// stream lengths / ofmap sizes and the write-address region select.
package sa_sched_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_W = 3'd1;
   localparam logic [2:0] S_LOAD_D = 3'd2;
   localparam logic [2:0] S_KICK   = 3'd3;
   localparam logic [2:0] S_RUN    = 3'd4;
   localparam logic [2:0] S_DRAIN  = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   localparam int W_LEN_DEF    = 1024;
   localparam int IDLE_GAP_DEF = 32;
   localparam int GAP_W_DEF    = 6;

   // addra[16] picks the destination memory
   localparam logic REGION_W = 1'b1;
   localparam logic REGION_D = 1'b0;

   function automatic logic [15:0] d_len(input logic [1:0] l);
      case (l)
         2'd0:    d_len = 16'd784;
         2'd1:    d_len = 16'd1176;
         default: d_len = 16'd400;
      endcase
   endfunction

   function automatic logic [4:0] ofmap_of(input logic [1:0] l);
      case (l)
         2'd0:    ofmap_of = 5'd24;
         2'd1:    ofmap_of = 5'd10;
         default: ofmap_of = 5'd1;
      endcase
   endfunction

endpackage

// File: rtl/sa_sched_loader.sv
// Load-stream front end: index counter, handshake and the registered
// shared write port into weight BRAM / ifmap SRAM.
module sa_sched_loader
   import sa_sched_pkg::*;
#(
   parameter int W_LEN = W_LEN_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  state,
   input  logic [1:0]  layer,
   input  logic        abort,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   output logic        last,
   output logic        wea,
   output logic [16:0] addra,
   output logic [7:0]  dia
);

   logic [15:0] idx;
   logic        is_w, is_d, hs;

   assign is_w    = (state == S_LOAD_W);
   assign is_d    = (state == S_LOAD_D);
   assign s_ready = is_w | is_d;
   assign hs      = s_valid & s_ready;
   assign last    = hs & (is_w ? (idx == 16'(W_LEN - 1)) : (idx == d_len(layer) - 16'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx   <= '0;
         wea   <= 1'b0;
         addra <= '0;
         dia   <= '0;
      end else begin
         // a handshake in the abort cycle still lands its write next cycle
         wea <= hs;
         if (hs) begin
            addra <= is_w ? {REGION_W, 6'b0, idx[9:0]} : {REGION_D, idx};
            dia   <= s_data;
         end
         if (abort || !s_ready)
            idx <= '0;
         else if (hs)
            idx <= last ? 16'd0 : idx + 16'd1;
      end
   end

endmodule

// File: rtl/sa_layer_sched.sv
// Layer scheduler: loads weights then ifmap per layer, kicks the array and
// waits for an IDLE_GAP quiet window. SA_SCHED_PERF_EN adds cycle counters.
module sa_layer_sched
   import sa_sched_pkg::*;
#(
   parameter int W_LEN    = W_LEN_DEF,
   parameter int IDLE_GAP = IDLE_GAP_DEF,
   parameter int GAP_W    = GAP_W_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go_i,
   input  logic [1:0]  num_layers_i,
   input  logic        abort_i,
   input  logic        s_valid_i,
   input  logic [7:0]  s_data_i,
   output logic        s_ready_o,
   output logic        sa_start_o,
   output logic [1:0]  sa_nth_conv_o,
   output logic [4:0]  sa_ofmap_size_o,
   output logic        sa_wea_o,
   output logic [16:0] sa_addra_o,
   output logic [7:0]  sa_dia_o,
   input  logic [15:0] accu_valid_i,
   output logic        busy_o,
   output logic        layer_done_o,
   output logic        done_o,
   output logic        err_o
`ifdef SA_SCHED_PERF_EN
   ,
   output logic [31:0] perf_load_cyc_o,
   output logic [31:0] perf_run_cyc_o
`endif
);

   logic [2:0]       state, state_nxt;
   logic [1:0]       layer, layer_nxt, num;
   logic [GAP_W-1:0] gap;
   logic             ld_last, any_v, gap_hit, go_ok;

   assign any_v   = |accu_valid_i;
   assign gap_hit = (state == S_DRAIN) && !any_v && (gap == GAP_W'(IDLE_GAP - 1));
   assign go_ok   = (state == S_IDLE) && go_i && (num_layers_i != 2'd0);
   assign busy_o  = (state != S_IDLE);
   assign done_o  = (state == S_DONE);

   sa_sched_loader #(.W_LEN(W_LEN)) u_loader (
      .clk     (clk),
      .rst_n   (rst_n),
      .state   (state),
      .layer   (layer),
      .abort   (abort_i),
      .s_valid (s_valid_i),
      .s_data  (s_data_i),
      .s_ready (s_ready_o),
      .last    (ld_last),
      .wea     (sa_wea_o),
      .addra   (sa_addra_o),
      .dia     (sa_dia_o)
   );

   always_comb begin
      state_nxt = state;
      layer_nxt = layer;
      case (state)
         S_IDLE:   if (go_ok) begin state_nxt = S_LOAD_W; layer_nxt = 2'd0; end
         S_LOAD_W: if (ld_last) state_nxt = S_LOAD_D;
         S_LOAD_D: if (ld_last) state_nxt = S_KICK;
         S_KICK:   state_nxt = S_RUN;
         S_RUN:    if (any_v) state_nxt = S_DRAIN;
         S_DRAIN:
            if (gap_hit) begin
               if (layer == num - 2'd1) state_nxt = S_DONE;
               else begin state_nxt = S_LOAD_W; layer_nxt = layer + 2'd1; end
            end
         default:  state_nxt = S_IDLE;
      endcase
      if (abort_i) begin
         state_nxt = S_IDLE;
         layer_nxt = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         layer           <= '0;
         num             <= '0;
         gap             <= '0;
         sa_start_o      <= 1'b0;
         layer_done_o    <= 1'b0;
         err_o           <= 1'b0;
         sa_nth_conv_o   <= '0;
         sa_ofmap_size_o <= '0;
      end else begin
         state <= state_nxt;
         layer <= layer_nxt;
         if (go_ok && !abort_i) num <= num_layers_i;
         gap <= ((state == S_DRAIN) && !any_v && !gap_hit && !abort_i) ? gap + 1'b1 : '0;
         // start leaves KICK one cycle after the final data write lands
         sa_start_o   <= (state == S_KICK) && !abort_i;
         layer_done_o <= gap_hit && !abort_i;
         err_o        <= (state == S_IDLE) && go_i && (num_layers_i == 2'd0) && !abort_i;
         // driven from the next layer so the value is already valid on LOAD_W entry
         sa_nth_conv_o   <= (state_nxt == S_IDLE) ? 2'd0 : layer_nxt;
         sa_ofmap_size_o <= (state_nxt == S_IDLE) ? 5'd0 : ofmap_of(layer_nxt);
      end
   end

`ifdef SA_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_load_cyc_o <= '0;
         perf_run_cyc_o  <= '0;
      end else if (go_ok && !abort_i) begin
         perf_load_cyc_o <= '0;
         perf_run_cyc_o  <= '0;
      end else begin
         if ((state == S_LOAD_W || state == S_LOAD_D) && perf_load_cyc_o != '1)
            perf_load_cyc_o <= perf_load_cyc_o + 32'd1;
         if ((state == S_KICK || state == S_RUN || state == S_DRAIN) && perf_run_cyc_o != '1)
            perf_run_cyc_o <= perf_run_cyc_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sa_layer_sched.sv
// Directed bench for sa_layer_sched: table of layer-sequence runs plus
// hand-written reset, illegal-go and async-reset sequences.
module tb_sa_layer_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        go_i;
   logic [1:0]  num_layers_i;
   logic        abort_i;
   logic        s_valid_i;
   logic [7:0]  s_data_i;
   logic        s_ready_o;
   logic        sa_start_o;
   logic [1:0]  sa_nth_conv_o;
   logic [4:0]  sa_ofmap_size_o;
   logic        sa_wea_o;
   logic [16:0] sa_addra_o;
   logic [7:0]  sa_dia_o;
   logic [15:0] accu_valid_i;
   logic        busy_o;
   logic        layer_done_o;
   logic        done_o;
   logic        err_o;

   sa_layer_sched dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .go_i            (go_i),
      .num_layers_i    (num_layers_i),
      .abort_i         (abort_i),
      .s_valid_i       (s_valid_i),
      .s_data_i        (s_data_i),
      .s_ready_o       (s_ready_o),
      .sa_start_o      (sa_start_o),
      .sa_nth_conv_o   (sa_nth_conv_o),
      .sa_ofmap_size_o (sa_ofmap_size_o),
      .sa_wea_o        (sa_wea_o),
      .sa_addra_o      (sa_addra_o),
      .sa_dia_o        (sa_dia_o),
      .accu_valid_i    (accu_valid_i),
      .busy_o          (busy_o),
      .layer_done_o    (layer_done_o),
      .done_o          (done_o),
      .err_o           (err_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int num;
      int pct;
      bit glitch;
      int abort_at;
      int exp_starts;
      int exp_ldone;
      int exp_done;
      int exp_w;
      int exp_d;
   } vec_t;

   vec_t tbl[6];
   int   exp_of[3] = '{24, 10, 1};
   int   exp_dl[3] = '{784, 1176, 400};

   task automatic run_vec(input vec_t v);
      int  k = 0, w_tot = 0, d_tot = 0, w_l = 0, d_l = 0;
      int  ldone = 0, dn = 0, acc_t = -1, last_v = 0, wr_bad = 0, trail = 0, abort_cyc = 0;
      bit  aborted = 0, fin = 0, hi;
      byte unsigned tx = 0;
      byte unsigned q[$];
      @(negedge clk);
      go_i = 1'b1;
      num_layers_i = v.num[1:0];
      for (int n = 0; n < 20000 && !fin; n++) begin
         @(negedge clk);
         go_i = 1'b0;
         abort_i = 1'b0;
         if (sa_wea_o) begin
            if (q.size() == 0) wr_bad++;
            else if (sa_dia_o != q.pop_front()) wr_bad++;
            if (sa_addra_o[16]) begin
               if (sa_addra_o != (17'h10000 | 17'(w_l))) wr_bad++;
               w_l++; w_tot++;
            end else begin
               if (sa_addra_o != 17'(d_l)) wr_bad++;
               d_l++; d_tot++;
            end
            if (sa_start_o) wr_bad++;
            if (aborted) trail++;
         end
         if (sa_start_o) begin
            if (k < 3) begin
               chk("start_nth_conv", sa_nth_conv_o, k);
               chk("start_ofmap", sa_ofmap_size_o, exp_of[k]);
               chk("weight_writes_layer", w_l, 1024);
               chk("data_writes_layer", d_l, exp_dl[k]);
            end
            k++; w_l = 0; d_l = 0; acc_t = 0;
            // stray go while the array is running
            go_i = 1'b1;
            num_layers_i = 2'd3;
         end
         if (layer_done_o) begin
            ldone++;
            chk("quiet_gap_to_layer_done", cyc - last_v, 32);
         end
         if (done_o) begin
            dn++;
            fin = 1;
         end
         hi = 0;
         if (acc_t >= 0) begin
            hi = (acc_t < 100) || (v.glitch && acc_t >= 131 && acc_t < 136);
            accu_valid_i = hi ? (16'h0001 << (acc_t % 16)) : 16'h0000;
            if (hi) last_v = cyc + 1;
            acc_t++;
         end
         s_valid_i = ($urandom_range(99) < v.pct);
         s_data_i = tx;
         if (s_valid_i && s_ready_o) begin
            q.push_back(tx);
            tx++;
         end
         if (v.abort_at >= 0 && !aborted && w_tot == v.abort_at) begin
            abort_i = 1'b1;
            aborted = 1;
            abort_cyc = cyc;
         end
         if (aborted && cyc == abort_cyc + 1) chk("busy_after_abort", busy_o, 0);
         if (aborted && cyc >= abort_cyc + 20) fin = 1;
      end
      if (!fin) chk("run_timeout", 0, 1);
      s_valid_i = 1'b0;
      accu_valid_i = '0;
      go_i = 1'b0;
      abort_i = 1'b0;
      chk("start_count", k, v.exp_starts);
      chk("layer_done_count", ldone, v.exp_ldone);
      chk("done_count", dn, v.exp_done);
      chk("write_addr_data_errs", wr_bad, 0);
      if (v.abort_at >= 0) begin
         chk("trailing_writes_le1", (trail <= 1), 1);
         chk("abort_weight_total", (w_tot >= v.abort_at && w_tot <= v.abort_at + 1), 1);
         chk("abort_data_total", d_tot, 0);
      end else begin
         chk("weight_total", w_tot, v.exp_w);
         chk("data_total", d_tot, v.exp_d);
      end
      repeat (2) @(negedge clk);
      chk("idle_busy", busy_o, 0);
      chk("idle_nth_conv", sa_nth_conv_o, 0);
      chk("idle_ofmap", sa_ofmap_size_o, 0);
   endtask

   initial begin
      tbl[0] = '{num:1, pct:100, glitch:0, abort_at:-1, exp_starts:1, exp_ldone:1, exp_done:1, exp_w:1024, exp_d:784};
      tbl[1] = '{num:3, pct:100, glitch:0, abort_at:-1, exp_starts:3, exp_ldone:3, exp_done:1, exp_w:3072, exp_d:2360};
      tbl[2] = '{num:1, pct:50,  glitch:0, abort_at:-1, exp_starts:1, exp_ldone:1, exp_done:1, exp_w:1024, exp_d:784};
      tbl[3] = '{num:1, pct:100, glitch:1, abort_at:-1, exp_starts:1, exp_ldone:1, exp_done:1, exp_w:1024, exp_d:784};
      tbl[4] = '{num:1, pct:100, glitch:0, abort_at:500, exp_starts:0, exp_ldone:0, exp_done:0, exp_w:0, exp_d:0};
      tbl[5] = '{num:2, pct:100, glitch:0, abort_at:-1, exp_starts:2, exp_ldone:2, exp_done:1, exp_w:2048, exp_d:1960};

      rst_n = 1'b0;
      go_i = 1'b0;
      num_layers_i = '0;
      abort_i = 1'b0;
      s_valid_i = 1'b0;
      s_data_i = '0;
      accu_valid_i = '0;
      #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_wea", sa_wea_o, 0);
      chk("rst_addra", sa_addra_o, 0);
      chk("rst_start", sa_start_o, 0);
      chk("rst_ready", s_ready_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // illegal go: zero layers
      @(negedge clk);
      go_i = 1'b1;
      num_layers_i = 2'd0;
      @(negedge clk);
      go_i = 1'b0;
      chk("err_pulse", err_o, 1);
      chk("err_busy", busy_o, 0);
      @(negedge clk);
      chk("err_one_cycle", err_o, 0);
      chk("err_still_idle", busy_o, 0);

      for (int i = 0; i < 6; i++) run_vec(tbl[i]);

      // async reset in the middle of a weight load
      @(negedge clk);
      go_i = 1'b1;
      num_layers_i = 2'd1;
      @(negedge clk);
      go_i = 1'b0;
      s_valid_i = 1'b1;
      repeat (300) @(negedge clk);
      chk("pre_reset_busy", busy_o, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", busy_o, 0);
      chk("async_rst_wea", sa_wea_o, 0);
      chk("async_rst_ready", s_ready_o, 0);
      chk("async_rst_addra", sa_addra_o, 0);
      @(negedge clk);
      s_valid_i = 1'b0;
      rst_n = 1'b1;
      run_vec(tbl[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sa_layer_sched.md
Name: sa_layer_sched

Overview:
Layer scheduler in front of the systolic-array top.
- Sequences 1-3 conv layers.
- For each layer it streams the weight image into the weight BRAM, then streams the ifmap into the input SRAM, both through the shared wea/addra/dia write port.
- It then pulses start with the layer's nth_conv/ofmap_size and waits for the accumulator outputs to go quiet before moving to the next layer.

Parameters:
W_LEN, 1024, bytes per layer weight image (full 16x64 weight BRAM refill)
IDLE_GAP, 32, consecutive cycles with all accu_valid low that mark layer completion
GAP_W, 6, width of gap counter (must hold IDLE_GAP)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
go_i  in  1  one-cycle request to run a layer sequence; sampled only in IDLE
num_layers_i  in  2  layers to run (1..3), captured on go_i
abort_i  in  1  synchronous abort, returns to IDLE
s_valid_i  in  1  load stream valid
s_data_i  in  8  load stream byte
s_ready_o  out  1  load stream ready
sa_start_o  out  1  start pulse to array
sa_nth_conv_o  out  2  current layer index
sa_ofmap_size_o  out  5  current ofmap size
sa_wea_o  out  1  shared write enable
sa_addra_o  out  17  write address; bit16=1 weight BRAM, bit16=0 ifmap SRAM
sa_dia_o  out  8  write data
accu_valid_i  in  16  per-column accumulator valid from array
busy_o  out  1  high in any non-IDLE state
layer_done_o  out  1  one-cycle pulse per completed layer
done_o  out  1  one-cycle pulse when the sequence completes
err_o  out  1  one-cycle pulse on illegal go (num_layers_i==0)

Behaviour:
- Reset: state IDLE. All outputs 0; counters 0.
- Per-layer constants (package):
  - layer 0: D_LEN 784, ofmap 24
  - layer 1: D_LEN 1176, ofmap 10
  - layer 2: D_LEN 400, ofmap 1
- States and transitions:
  - IDLE: on go_i with num_layers_i!=0, capture it, set layer=0, go to LOAD_W. With num_layers_i==0, pulse err_o and stay. go_i outside IDLE is ignored.
  - LOAD_W: s_ready_o=1. Each handshake (s_valid_i&s_ready_o) registers a write next cycle: sa_wea_o=1, sa_addra_o={1'b1,6'b0,idx[9:0]}, sa_dia_o=s_data_i. Write latency is 1 cycle. On the handshake with idx==W_LEN-1, clear idx and go to LOAD_D.
  - LOAD_D: same handshake and latency, with sa_addra_o={1'b0,idx[15:0]}. On the handshake with idx==D_LEN[layer]-1, clear idx and go to KICK.
  - KICK: s_ready_o=0; sa_start_o=1 for exactly one cycle; go to RUN. The final data write and sa_start_o never share a cycle: the write lands in the KICK cycle and start is registered out of KICK.
  - RUN: wait until |accu_valid_i, then go to DRAIN. There is no timeout.
  - DRAIN: gap counter clears when |accu_valid_i and increments otherwise. When gap==IDLE_GAP-1 with all valid low, pulse layer_done_o. Then, if layer==num-1, go to DONE; otherwise layer++ and go to LOAD_W.
  - DONE: pulse done_o for one cycle, then go to IDLE.
- sa_nth_conv_o and sa_ofmap_size_o are registered from layer. They are stable from LOAD_W entry through DRAIN exit, and return to 0 in IDLE.
- s_ready_o is combinational from state (LOAD_W/LOAD_D only). A stalled stream (s_valid_i low) holds idx with no write.
- sa_wea_o is 0 in every cycle without a prior-cycle handshake.
- abort_i has priority over all transitions: next state IDLE, counters cleared, no done pulse. A write registered in the abort cycle still issues the following cycle; no write issues after that.
- Asynchronous reset mid-operation forces IDLE immediately; outputs return to reset values.

Optional Feature:
SA_SCHED_PERF_EN
- Defined: adds outputs perf_load_cyc_o[31:0] and perf_run_cyc_o[31:0].
  - perf_load_cyc_o counts cycles in LOAD_W/LOAD_D; perf_run_cyc_o counts cycles in KICK/RUN/DRAIN.
  - Both clear on accepted go_i, saturate at all-ones, and hold after done_o.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package sa_sched_pkg holds:
  - state enum: IDLE, LOAD_W, LOAD_D, KICK, RUN, DRAIN, DONE
  - D_LEN and OFMAP per-layer constant arrays
  - W_LEN default
  - address-region constant (bit16 select)
- One sub-module, sa_sched_loader: idx counter, handshake and registered write port; handles both regions, selected by state.
- The top holds the FSM, layer counter and gap counter.

Test Plan:
- go_i with num_layers_i=1, stream always valid: exactly 1024 writes at 0x10000-0x103FF, then 784 writes at 0x00000-0x0030F. One sa_start_o pulse with nth_conv=0 and ofmap=24. Model accu_valid for 100 cycles; done_o arrives IDLE_GAP cycles after the last valid.
- num_layers_i=3: three start pulses with (nth_conv, ofmap) = (0,24), (1,10), (2,1); data write counts 784, 1176, 400; three layer_done_o pulses, then one done_o.
- Random s_valid_i gaps (50%) in LOAD_D: no write in cycles after non-handshake; addresses contiguous; total writes unchanged.
- accu_valid_i drops for IDLE_GAP-1 cycles then reasserts in DRAIN: no layer_done_o; completion only after a full 32-cycle gap.
- abort_i at weight write 500: one trailing write at most, busy_o=0 the next cycle, no done_o. A new go_i then restarts at weight address 0x10000.
- go_i with num_layers_i=0: err_o pulse, busy_o stays 0. go_i asserted during RUN: ignored; exactly one start per layer.
